// File: rtl/ysyx_22050612_mem_resp_if.sv
// ysyx_22050612_mem_resp_if: request/response bus between a requester and the memory responder
//   req_valid/req_ready  request handshake
//   req_wen              1 = write, 0 = read
//   req_addr             byte address
//   req_wdata/req_wmask  write data with per-byte enables
//   resp_valid/resp_ready response handshake
//   resp_rdata/resp_err  read data (0 for writes and errors) and out-of-range flag
interface ysyx_22050612_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_22050612_mem_resp.sv
// ysyx_22050612_mem_resp: single-outstanding memory responder with fixed response latency
//   clk  sole clock
//   rst  synchronous active-high reset (array contents are kept)
//   bus  request/response interface, slave side
module ysyx_22050612_mem_resp #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22050612_mem_resp_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [63:0]   off;
  logic [AW-1:0] idx;
  logic          acc, bad, done;
  logic [63:0]   mem_q [DEPTH];
  assign bus.req_ready  = state_q == IDLE && !rst;
  assign acc            = bus.req_valid && bus.req_ready;
  // Range is judged on the offset so ADDR_BASE + span never has to be formed (no wrap aliasing).
  assign off            = bus.req_addr - ADDR_BASE;
  assign bad            = bus.req_addr < ADDR_BASE || off >= SPAN;
  assign idx            = off[AW+2:3];
  assign done           = state_q == RESP && bus.resp_ready;
  assign bus.resp_valid = state_q == RESP;
  // Read data is captured at accept, so it must be masked while still waiting.
  assign bus.resp_rdata = state_q == RESP ? rdata_q : '0;
  assign bus.resp_err   = state_q == RESP && err_q;
  always_comb begin
    state_d = acc ? (LATENCY > 1 ? WAIT : RESP) :
              done ? IDLE :
              (state_q == WAIT && cnt_q == LAST) ? RESP : state_q;
    cnt_d   = state_q == WAIT ? cnt_q + 1'b1 : '0;
    rdata_d = acc ? (bus.req_wen || bad ? '0 : mem_q[idx]) : done ? '0 : rdata_q;
    err_d   = acc ? bad : done ? 1'b0 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc && bus.req_wen && !bad)
      for (int i = 0; i < 8; i++)
        if (bus.req_wmask[i]) mem_q[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_22050612_mem_resp.sv
// tb_ysyx_22050612_mem_resp: directed table-driven bench for the memory responder
module tb_ysyx_22050612_mem_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_22050612_mem_resp_if b0();
  ysyx_22050612_mem_resp_if b1();
  ysyx_22050612_mem_resp #(.LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ysyx_22050612_mem_resp #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        err;
  } vec_t;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk1(input string n, input logic a, input logic e);
    chk(n, 64'(a), 64'(e));
  endtask
  task automatic xfer(input vec_t v, input string n);
    int t;
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_wen   = v.wen;
    b0.req_addr  = v.addr;
    b0.req_wdata = v.wdata;
    b0.req_wmask = v.wmask;
    t = 0;
    while (!b0.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk1({n, " req_ready"}, b0.req_ready, 1'b1);
    @(negedge clk);
    b0.req_valid = 1'b0;
    t = 1;
    while (!b0.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({n, " latency"}, 64'(t), 64'd2);
    chk({n, " rdata"}, b0.resp_rdata, v.rdata);
    chk1({n, " err"}, b0.resp_err, v.err);
    b0.resp_ready = 1'b1;
    @(negedge clk);
    b0.resp_ready = 1'b0;
    chk1({n, " idle valid"}, b0.resp_valid, 1'b0);
    chk1({n, " idle ready"}, b0.req_ready, 1'b1);
    chk({n, " idle rdata"}, b0.resp_rdata, 64'd0);
  endtask
  vec_t tbl [15];
  vec_t v;
  logic [63:0] held;
  initial begin
    tbl[0]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
    tbl[2]  = '{1'b1, 64'h8000_0000, 64'h0, 8'hFF, 64'h0, 1'b0};
    tbl[3]  = '{1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b0};
    tbl[4]  = '{1'b0, 64'h8000_0004, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0};
    tbl[5]  = '{1'b1, 64'h8000_0000, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0, 1'b0};
    tbl[6]  = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0};
    tbl[7]  = '{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[8]  = '{1'b0, 64'h8000_2000, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[9]  = '{1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0, 1'b1};
    tbl[10] = '{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0};
    tbl[11] = '{1'b1, 64'h8000_1FF8, 64'h0102_0304_0506_0708, 8'hA5, 64'h0, 1'b0};
    tbl[12] = '{1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1};
    tbl[13] = '{1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0100_0300_0006_0008 & 64'hFF00_FF00_00FF_00FF, 1'b0};
    tbl[14] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};
    b0.req_valid = 1'b1; b0.req_wen = 1'b1; b0.req_addr = 64'h8000_0000;
    b0.req_wdata = 64'h5555; b0.req_wmask = 8'hFF; b0.resp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_wen = 1'b0; b1.req_addr = 64'h0;
    b1.req_wdata = 64'h0; b1.req_wmask = 8'h00; b1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset req_ready", b0.req_ready, 1'b0);
    chk1("reset resp_valid", b0.resp_valid, 1'b0);
    chk("reset resp_rdata", b0.resp_rdata, 64'd0);
    chk1("reset resp_err", b0.resp_err, 1'b0);
    b0.req_valid = 1'b0; b0.resp_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk1("post-reset req_ready", b0.req_ready, 1'b1);
    for (int i = 0; i < 15; i++) xfer(tbl[i], $sformatf("vec%0d", i));
    // backpressure: response held for 5 cycles while a competing write is presented
    v = '{1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_wen = 1'b0; b0.req_addr = 64'h8000_0010;
    @(negedge clk);
    b0.req_wen = 1'b1; b0.req_wdata = 64'h9999_9999_9999_9999; b0.req_wmask = 8'hFF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk1($sformatf("bp valid %0d", k), b0.resp_valid, 1'b1);
      chk($sformatf("bp rdata %0d", k), b0.resp_rdata, v.rdata);
      chk1($sformatf("bp err %0d", k), b0.resp_err, 1'b0);
      chk1($sformatf("bp req_ready %0d", k), b0.req_ready, 1'b0);
      @(negedge clk);
    end
    b0.req_valid = 1'b0; b0.resp_ready = 1'b1;
    @(negedge clk);
    b0.resp_ready = 1'b0;
    chk1("bp after handshake req_ready", b0.req_ready, 1'b1);
    xfer(v, "bp ignored write");
    // request during reset must not be accepted nor write the array
    @(negedge clk);
    rst = 1'b1;
    b0.req_valid = 1'b1; b0.req_wen = 1'b1; b0.req_addr = 64'h8000_0010;
    b0.req_wdata = 64'h5555_5555_5555_5555; b0.req_wmask = 8'hFF;
    @(negedge clk);
    chk1("rst req_ready", b0.req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0; b0.req_valid = 1'b0;
    xfer(v, "rst request ignored");
    // reset in WAIT after a committed write
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_wen = 1'b1; b0.req_addr = 64'h8000_0000;
    b0.req_wdata = 64'hAAAA_AAAA_AAAA_AAAA; b0.req_wmask = 8'hFF;
    chk1("midwait ready", b0.req_ready, 1'b1);
    @(negedge clk);
    b0.req_valid = 1'b0; b0.resp_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held = 64'd0;
    for (int k = 0; k < 4; k++) begin
      held = held | 64'(b0.resp_valid);
      @(negedge clk);
    end
    b0.resp_ready = 1'b0;
    chk("midwait resp_valid seen", held, 64'd0);
    xfer('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0}, "midwait read");
    // LATENCY=1 instance: back-to-back writes every 2 cycles, then a read
    b1.req_valid = 1'b1; b1.req_wen = 1'b1; b1.req_addr = 64'h8000_0008;
    b1.req_wdata = 64'h0000_0000_0000_0077; b1.req_wmask = 8'hFF; b1.resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk1($sformatf("lat1 req_ready %0d", k), b1.req_ready, k % 2 == 0);
      chk1($sformatf("lat1 resp_valid %0d", k), b1.resp_valid, k % 2 == 1);
      @(negedge clk);
    end
    b1.req_wen = 1'b0;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk1("lat1 read valid", b1.resp_valid, 1'b1);
    chk("lat1 read rdata", b1.resp_rdata, 64'h77);
    chk1("lat1 read err", b1.resp_err, 1'b0);
    @(negedge clk);
    chk1("lat1 idle", b1.resp_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
